ram_access_arbiter: RTL and testbench
=====================================

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, is the data word width.
REQ-002 Parameter ADDR_W, default 4, is the RAM address width (16 words).
REQ-003 clk  in  1  is the single clock; all state updates on rising edge.
REQ-004 rst  in  1  is the reset: synchronous, active-high.
REQ-005 req0, req1  in  1 each  are the access requests from channel 0 and channel 1.
REQ-006 we0, we1  in  1 each  select the operation: 1 = write, 0 = read.
REQ-007 addr0, addr1  in  ADDR_W each  carry the target address.
REQ-008 wdata0, wdata1  in  DATA_W each  carry the write data.
REQ-009 ack0, ack1  out  1 each  are single-cycle completion pulses per channel.
REQ-010 rvalid0, rvalid1  out  1 each  are single-cycle read-data-valid pulses per channel.
REQ-011 rdata  out  DATA_W  is the shared read-data register.
REQ-012 busy  out  1  is high whenever the FSM is not in IDLE.
REQ-013 ram_we  out  1  is the RAM write enable.
REQ-014 ram_waddr  out  ADDR_W  is the RAM write address.
REQ-015 ram_wdata  out  DATA_W  is the RAM write data.
REQ-016 ram_raddr  out  ADDR_W  is the RAM read address.
REQ-017 ram_rdata  in  DATA_W  is the RAM read data, valid 1 cycle after ram_raddr is presented (synchronous read).

Function
REQ-018 FSM states SHALL be IDLE, WR, RD_ADDR and RD_DATA; all outputs are Moore (registered state / latched command) only.
REQ-019 In IDLE with any req high, the FSM SHALL select a winner, latch its we/addr/wdata, and go to WR (we=1) or RD_ADDR (we=0); with no req it stays in IDLE.
REQ-020 Arbitration SHALL be round-robin: a single requester always wins; when both request, the channel not granted last wins; the last-grant pointer updates only on a grant.
REQ-021 In WR: ram_we=1, ram_waddr and ram_wdata come from the latched command, ack of the winner=1; next state is IDLE.
REQ-022 In RD_ADDR: ram_raddr comes from the latched address, ram_we=0; next state is RD_DATA.
REQ-023 In RD_DATA: rdata is loaded from ram_rdata at the cycle end; ack and rvalid of the winner are both 1 in the cycle following RD_DATA; next state is IDLE.
REQ-024 Latency, measured from the IDLE cycle sampling req: write ack in cycle +1; read rvalid/ack in cycle +3. Throughput is 1 write per 2 cycles and 1 read per 3 cycles.
REQ-025 A requester SHALL hold req and its command stable until its ack; it deasserts req, or presents a new command, in the cycle after ack.
REQ-026 rdata SHALL hold its value until the next read completes, and SHALL be unchanged by writes.
REQ-027 Outside WR, ram_we SHALL be 0; ram_waddr, ram_wdata and ram_raddr SHALL hold their last latched values.
REQ-028 A req arriving while busy=1 SHALL wait, with no loss and no reordering within a channel.
REQ-029 A read and a write to the same address are serialized by the arbiter, so read data always reflects every previously acked write.
REQ-030 The ack and rvalid of the non-winning channel SHALL stay 0.

Reset
REQ-031 With rst=1 at a rising edge: state=IDLE; ram_we, ack0/1, rvalid0/1 and busy are 0; rdata, ram_waddr, ram_wdata and ram_raddr are 0; the last-grant pointer points to channel 1, so channel 0 wins the first contention.
REQ-032 Reset in any state SHALL abort the operation: no ack or rvalid is issued for it, and ram_we=0 from the next cycle.

Verification
REQ-033 Reset, then req0 write addr=3 wdata=0xA5 -> ram_we=1, ram_waddr=3, ram_wdata=0xA5, ack0=1 one cycle after sampling; busy high for 1 cycle.
REQ-034 After REQ-033, req1 read addr=3 -> ram_raddr=3, then rvalid1=ack1=1 with rdata=0xA5 three cycles after sampling.
REQ-035 Both channels request writes continuously (ch0 addr=1 data=0x11, ch1 addr=2 data=0x22) -> grants alternate 0,1,0,1 starting with ch0; each ack aligns with a ram_we pulse.
REQ-036 rst asserted during RD_ADDR of a ch0 read -> no rvalid0 or ack0; state=IDLE, rdata=0 next cycle; a subsequent read works normally.
REQ-037 ch0 read addr=5 while ch1 writes addr=5 data=0x3C with ch1 granted first -> ch0 receives rdata=0x3C.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Bundle for the two requester channels and the RAM port of ram_access_arbiter.
// master: requesters plus RAM side. slave: the arbiter.
interface ram_access_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    // Channel request side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;

    // Channel response side
    logic              ack0;
    logic              ack1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // RAM port
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  ack0, ack1, rvalid0, rvalid1, rdata, busy,
        input  ram_we, ram_waddr, ram_wdata, ram_raddr
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output ack0, ack1, rvalid0, rvalid1, rdata, busy,
        output ram_we, ram_waddr, ram_wdata, ram_raddr
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Two-channel round-robin arbiter in front of a single-port synchronous-read RAM.
// Writes take one WR cycle; reads take RD_ADDR + RD_DATA and complete with a
// registered ack/rvalid pulse in the following (IDLE) cycle.
module ram_access_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_access_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]        req_vec;
    logic [1:0]        req_eff;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];

    // grant_reg is both the latched winner and the round-robin last-grant pointer
    logic              grant_reg;
    logic              win;
    logic [1:0]        rd_done_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [ADDR_W-1:0] raddr_reg;
    logic [1:0]        ack_vec;
    logic              ram_we_int;
    logic              busy_int;

    assign req_vec      = {bus.req1, bus.req0};
    assign we_vec       = {bus.we1, bus.we0};
    assign addr_vec[0]  = bus.addr0;
    assign addr_vec[1]  = bus.addr1;
    assign wdata_vec[0] = bus.wdata0;
    assign wdata_vec[1] = bus.wdata1;

    // A channel whose read completes this cycle still holds its old request;
    // mask it so the stale command is not granted a second time.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            assign req_eff[gi] = req_vec[gi] & ~rd_done_reg[gi];
        end
    endgenerate

    // Round-robin pick: contention goes to the channel not granted last
    assign win = (req_eff == 2'b11) ? ~grant_reg : req_eff[1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (|req_eff) begin
                    state_next = we_vec[win] ? WR : RD_ADDR;
                end
            end
            WR:      state_next = IDLE;
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, grant pointer, read-data capture and read-completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg   <= 1'b1;
            rd_done_reg <= 2'b00;
            rdata_reg   <= '0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            raddr_reg   <= '0;
        end else begin
            rd_done_reg <= 2'b00;
            if (state_reg == IDLE && (|req_eff)) begin
                grant_reg <= win;
                if (we_vec[win]) begin
                    waddr_reg <= addr_vec[win];
                    wdata_reg <= wdata_vec[win];
                end else begin
                    raddr_reg <= addr_vec[win];
                end
            end
            if (state_reg == RD_DATA) begin
                rdata_reg              <= bus.ram_rdata;
                rd_done_reg[grant_reg] <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from state and registered completion flags
    always_comb begin
        ack_vec    = rd_done_reg;
        ram_we_int = 1'b0;
        busy_int   = (state_reg != IDLE);
        if (state_reg == WR) begin
            ram_we_int         = 1'b1;
            ack_vec[grant_reg] = 1'b1;
        end
    end

    assign bus.ack0      = ack_vec[0];
    assign bus.ack1      = ack_vec[1];
    assign bus.rvalid0   = rd_done_reg[0];
    assign bus.rvalid1   = rd_done_reg[1];
    assign bus.rdata     = rdata_reg;
    assign bus.busy      = busy_int;
    assign bus.ram_we    = ram_we_int;
    assign bus.ram_waddr = waddr_reg;
    assign bus.ram_wdata = wdata_reg;
    assign bus.ram_raddr = raddr_reg;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter: directed scenarios, then randomized
// two-channel traffic checked against a transaction-level memory model.
module tb_ram_access_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ram_access_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    ram_access_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM attached to the arbiter
    logic [7:0] ram_mem [16];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_rdata <= ram_mem[bus.ram_raddr];
    end

    // Reference memory: updated when a write is acknowledged
    logic [7:0] model_mem [16];
    logic [7:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic req, input logic we,
                          input logic [3:0] addr, input logic [7:0] wdata);
        if (ch == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    function automatic logic ack_of(input int ch);
        return (ch == 0) ? bus.ack0 : bus.ack1;
    endfunction

    function automatic logic rvalid_of(input int ch);
        return (ch == 0) ? bus.rvalid0 : bus.rvalid1;
    endfunction

    // Lone write: ack and RAM write pulse one cycle after the sampling cycle
    task automatic do_write(input int ch, input logic [3:0] addr, input logic [7:0] data);
        set_ch(ch, 1'b1, 1'b1, addr, data);
        tick();
        check("wr_ram_we", bus.ram_we, 1);
        check("wr_waddr", bus.ram_waddr, addr);
        check("wr_wdata", bus.ram_wdata, data);
        check("wr_ack", ack_of(ch), 1);
        check("wr_ack_other", ack_of(1 - ch), 0);
        check("wr_busy", bus.busy, 1);
        tick();
        check("wr_busy_done", bus.busy, 0);
        check("wr_we_done", bus.ram_we, 0);
        check("wr_ack_done", ack_of(ch), 0);
        model_mem[addr] = data;
        set_ch(ch, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // Lone read: address phase, data phase, then ack+rvalid three cycles after sampling
    task automatic do_read(input int ch, input logic [3:0] addr);
        set_ch(ch, 1'b1, 1'b0, addr, 8'd0);
        tick();
        check("rd_raddr", bus.ram_raddr, addr);
        check("rd_busy1", bus.busy, 1);
        check("rd_we0", bus.ram_we, 0);
        check("rd_ack_early1", ack_of(ch), 0);
        tick();
        check("rd_busy2", bus.busy, 1);
        check("rd_ack_early2", ack_of(ch), 0);
        check("rd_rvalid_early2", rvalid_of(ch), 0);
        tick();
        check("rd_ack", ack_of(ch), 1);
        check("rd_rvalid", rvalid_of(ch), 1);
        check("rd_rvalid_other", rvalid_of(1 - ch), 0);
        check("rd_rdata", bus.rdata, model_mem[addr]);
        check("rd_busy3", bus.busy, 0);
        tick();
        check("rd_no_regrant", bus.busy, 0);
        check("rd_pulse_single", rvalid_of(ch), 0);
        exp_rdata = model_mem[addr];
        set_ch(ch, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // Random-phase requester bookkeeping
    logic       act      [2];
    logic       cwe      [2];
    logic [3:0] caddr    [2];
    logic [7:0] cwdata   [2];
    int         wait_cnt [2];
    logic       done_now [2];
    logic [1:0] acks;
    logic [1:0] rvs;
    logic       exp_we;
    logic       any_rv;

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i]   = 8'd0;
            model_mem[i] = 8'd0;
        end
        exp_rdata = 8'd0;
        rst = 1'b1;
        set_ch(0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_ch(1, 1'b0, 1'b0, 4'd0, 8'd0);
        tick(); tick(); tick();

        // Reset state
        check("rst_ack0", bus.ack0, 0);
        check("rst_ack1", bus.ack1, 0);
        check("rst_rvalid0", bus.rvalid0, 0);
        check("rst_rvalid1", bus.rvalid1, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_waddr", bus.ram_waddr, 0);
        check("rst_wdata", bus.ram_wdata, 0);
        check("rst_raddr", bus.ram_raddr, 0);
        rst = 1'b0;
        tick();

        // ch0 write, then ch1 read back
        do_write(0, 4'd3, 8'hA5);
        do_read(1, 4'd3);

        // Both channels write continuously: grants alternate starting with ch0
        set_ch(0, 1'b1, 1'b1, 4'd1, 8'h11);
        set_ch(1, 1'b1, 1'b1, 4'd2, 8'h22);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_ack0", bus.ack0, (k % 2 == 0) ? 1 : 0);
            check("rr_ack1", bus.ack1, (k % 2 == 1) ? 1 : 0);
            check("rr_ram_we", bus.ram_we, 1);
            check("rr_waddr", bus.ram_waddr, (k % 2 == 0) ? 1 : 2);
            tick();
            check("rr_gap_we", bus.ram_we, 0);
            check("rr_gap_ack", {bus.ack1, bus.ack0}, 0);
        end
        set_ch(0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_ch(1, 1'b0, 1'b0, 4'd0, 8'd0);
        model_mem[1] = 8'h11;
        model_mem[2] = 8'h22;
        tick();

        // Reset during RD_ADDR aborts the read
        set_ch(0, 1'b1, 1'b0, 4'd3, 8'd0);
        tick();
        check("ab_busy_pre", bus.busy, 1);
        rst = 1'b1;
        tick();
        check("ab_busy", bus.busy, 0);
        check("ab_rdata", bus.rdata, 0);
        check("ab_ack0", bus.ack0, 0);
        check("ab_rvalid0", bus.rvalid0, 0);
        rst = 1'b0;
        set_ch(0, 1'b0, 1'b0, 4'd0, 8'd0);
        tick();
        check("ab_ack0_late", bus.ack0, 0);
        check("ab_rvalid0_late", bus.rvalid0, 0);
        check("ab_busy_late", bus.busy, 0);
        exp_rdata = 8'd0;
        do_read(0, 4'd3);

        // ch1 write granted first, then ch0 read of the same address sees it
        set_ch(0, 1'b1, 1'b0, 4'd5, 8'd0);
        set_ch(1, 1'b1, 1'b1, 4'd5, 8'h3C);
        tick();
        check("raw_ack1", bus.ack1, 1);
        check("raw_ack0_first", bus.ack0, 0);
        check("raw_waddr", bus.ram_waddr, 5);
        check("raw_wdata", bus.ram_wdata, 8'h3C);
        tick();
        set_ch(1, 1'b0, 1'b0, 4'd0, 8'd0);
        model_mem[5] = 8'h3C;
        tick();
        check("raw_raddr", bus.ram_raddr, 5);
        tick();
        check("raw_no_early", bus.rvalid0, 0);
        tick();
        check("raw_ack0", bus.ack0, 1);
        check("raw_rvalid0", bus.rvalid0, 1);
        check("raw_rdata", bus.rdata, 8'h3C);
        tick();
        set_ch(0, 1'b0, 1'b0, 4'd0, 8'd0);
        exp_rdata = 8'h3C;
        tick();

        // Randomized traffic on both channels
        for (int ch = 0; ch < 2; ch++) begin
            act[ch] = 1'b0; cwe[ch] = 1'b0; caddr[ch] = 4'd0; cwdata[ch] = 8'd0;
            wait_cnt[ch] = 0; done_now[ch] = 1'b0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            acks   = {bus.ack1, bus.ack0};
            rvs    = {bus.rvalid1, bus.rvalid0};
            exp_we = 1'b0;
            any_rv = 1'b0;
            check("rand_one_ack", (acks == 2'b11) ? 1 : 0, 0);
            for (int ch = 0; ch < 2; ch++) begin
                done_now[ch] = 1'b0;
                if (acks[ch]) begin
                    check("rand_ack_pending", act[ch], 1);
                    if (act[ch]) begin
                        if (cwe[ch]) begin
                            exp_we = 1'b1;
                            check("rand_wr_waddr", bus.ram_waddr, caddr[ch]);
                            check("rand_wr_wdata", bus.ram_wdata, cwdata[ch]);
                            check("rand_wr_rvalid", rvs[ch], 0);
                            model_mem[caddr[ch]] = cwdata[ch];
                        end else begin
                            any_rv = 1'b1;
                            check("rand_rd_rvalid", rvs[ch], 1);
                            check("rand_rd_rdata", bus.rdata, model_mem[caddr[ch]]);
                            exp_rdata = model_mem[caddr[ch]];
                        end
                        act[ch]      = 1'b0;
                        done_now[ch] = 1'b1;
                    end
                end else begin
                    check("rand_rvalid_no_ack", rvs[ch], 0);
                end
            end
            check("rand_ram_we", bus.ram_we, exp_we);
            if (!any_rv) check("rand_rdata_hold", bus.rdata, exp_rdata);
            for (int ch = 0; ch < 2; ch++) begin
                if (act[ch]) begin
                    wait_cnt[ch]++;
                    if (wait_cnt[ch] > 12) begin
                        check("rand_latency", wait_cnt[ch], 12);
                        act[ch] = 1'b0;
                        set_ch(ch, 1'b0, 1'b0, 4'd0, 8'd0);
                    end
                end else if (!done_now[ch]) begin
                    if (cyc < 780 && $urandom_range(0, 2) != 0) begin
                        act[ch]      = 1'b1;
                        cwe[ch]      = 1'($urandom_range(0, 1));
                        caddr[ch]    = 4'($urandom_range(0, 15));
                        cwdata[ch]   = 8'($urandom_range(0, 255));
                        wait_cnt[ch] = 0;
                        set_ch(ch, 1'b1, cwe[ch], caddr[ch], cwdata[ch]);
                    end else begin
                        set_ch(ch, 1'b0, 1'b0, 4'd0, 8'd0);
                    end
                end
            end
        end
        check("rand_drain_ch0", act[0], 0);
        check("rand_drain_ch1", act[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
